// File: rtl/pwm_regs_mc_if.sv
// rtl/pwm_regs_mc_if.sv - register bus bundle for the PWM channel register block
// Purpose: groups the byte-wide register bus so the block and its bus master
//          share one connection point.
// Signals:
//   read, write  - bus strobes, sampled on the clk rising edge
//   addr[7:0]    - [7:5] channel, [4:0] register offset
//   data_write   - write data byte
//   data_read    - registered read data byte
interface pwm_regs_mc_if;
  logic       read;
  logic       write;
  logic [7:0] addr;
  logic [7:0] data_write;
  logic [7:0] data_read;

  modport master (
    output read,
    output write,
    output addr,
    output data_write,
    input  data_read
  );

  modport slave (
    input  read,
    input  write,
    input  addr,
    input  data_write,
    output data_read
  );
endinterface

// File: rtl/pwm_regs_mc.sv
// rtl/pwm_regs_mc.sv - multi-channel PWM register file with shadowed period/compare
// Purpose: per-channel PERIOD/COMPARE1/COMPARE2 shadow+active registers,
//          unshadowed CTRL/PRESCALE/FUNCTIONS, counter snapshot for coherent
//          multi-byte counter reads, and a one-cycle counter reset pulse.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   bus                 - register bus (pwm_regs_mc_if.slave)
//   counter_val         - live counters, channel ch at [ch*CNT_W +: CNT_W]
//   update_strobe       - per-channel period-end pulse, loads shadows
//   period/compare1/2   - active values, sliced as counter_val
//   en, upnotdown,
//   pwm_en              - CTRL bits per channel
//   count_reset         - one-cycle pulse per COUNTER_RESET write
//   upd_pending         - shadow write waiting for update_strobe
//   prescale, functions - per-channel bytes at [ch*8 +: 8]
module pwm_regs_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pwm_regs_mc_if.slave            bus,
  input  logic [NUM_CH*CNT_W-1:0] counter_val,
  input  logic [NUM_CH-1:0]       update_strobe,
  output logic [NUM_CH*CNT_W-1:0] period,
  output logic [NUM_CH*CNT_W-1:0] compare1,
  output logic [NUM_CH*CNT_W-1:0] compare2,
  output logic [NUM_CH-1:0]       en,
  output logic [NUM_CH-1:0]       upnotdown,
  output logic [NUM_CH-1:0]       pwm_en,
  output logic [NUM_CH-1:0]       count_reset,
  output logic [NUM_CH-1:0]       upd_pending,
  output logic [NUM_CH*8-1:0]     prescale,
  output logic [NUM_CH*8-1:0]     functions
);

  localparam int NB = CNT_W / 8;

  localparam logic [4:0] OFF_CNT0   = 5'h0C;
  localparam logic [4:0] OFF_CRESET = 5'h13;

  // Byte lane helpers; lanes at or above NB do not exist and are skipped.
  function automatic logic [CNT_W-1:0] put_byte(input logic [CNT_W-1:0] v,
                                                input logic [1:0]       idx,
                                                input logic [7:0]       b);
    logic [CNT_W-1:0] r;
    r = v;
    for (int k = 0; k < NB; k++) begin
      if (int'(idx) == k) r[k*8 +: 8] = b;
    end
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [CNT_W-1:0] v,
                                          input logic [1:0]       idx);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < NB; k++) begin
      if (int'(idx) == k) r = v[k*8 +: 8];
    end
    return r;
  endfunction

  logic [2:0] ch_idx;
  logic [4:0] off;
  logic       ch_valid;
  logic       byte_ok;
  logic       wr_ok;
  logic       rd_ok;

  assign ch_idx   = bus.addr[7:5];
  assign off      = bus.addr[4:0];
  assign ch_valid = ({1'b0, ch_idx} < 4'(NUM_CH));
  assign byte_ok  = (int'(off[1:0]) < NB);
  assign wr_ok    = bus.write && ch_valid;
  assign rd_ok    = bus.read && ch_valid;

  logic [7:0] rd_byte [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic             wr_sel;
    logic             rd_sel;
    logic [2:0]       fwr;
    logic [CNT_W-1:0] sh     [3];
    logic [CNT_W-1:0] sh_nx  [3];
    logic [CNT_W-1:0] act    [3];
    logic [CNT_W-1:0] snap;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       ctrl;
    logic [7:0]       psc;
    logic [7:0]       fn;
    logic             crst;
    logic             pend;
    logic             bypass;
    logic             load;
    logic [7:0]       rb;

    assign wr_sel = wr_ok && (ch_idx == 3'(g));
    assign rd_sel = rd_ok && (ch_idx == 3'(g));
    assign cnt    = counter_val[g*CNT_W +: CNT_W];
    assign bypass = ctrl[3];
    // Strobe-driven load only applies in shadowed mode; in bypass mode the
    // active copy follows each write directly.
    assign load   = update_strobe[g] && !bypass;

    // Field 0 PERIOD, 1 COMPARE1, 2 COMPARE2; the merged next-shadow value is
    // what gets loaded on a coincident strobe, so the new byte wins.
    always_comb begin
      for (int f = 0; f < 3; f++) begin
        fwr[f]   = wr_sel && (off[4:2] == 3'(f)) && byte_ok;
        sh_nx[f] = fwr[f] ? put_byte(sh[f], off[1:0], bus.data_write) : sh[f];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int f = 0; f < 3; f++) begin
          sh[f]  <= '0;
          act[f] <= '0;
        end
        snap <= '0;
        ctrl <= '0;
        psc  <= '0;
        fn   <= '0;
        crst <= 1'b0;
        pend <= 1'b0;
      end else begin
        for (int f = 0; f < 3; f++) begin
          sh[f] <= sh_nx[f];
          if (load || (fwr[f] && bypass)) act[f] <= sh_nx[f];
        end
        if (load) begin
          pend <= 1'b0;
        end else if ((|fwr) && !bypass) begin
          pend <= 1'b1;
        end
        if (wr_sel && off == 5'h10) ctrl <= bus.data_write[3:0];
        if (wr_sel && off == 5'h11) psc  <= bus.data_write;
        if (wr_sel && off == 5'h12) fn   <= bus.data_write;
        crst <= wr_sel && (off == OFF_CRESET);
        if (rd_sel && off == OFF_CNT0) snap <= cnt;
      end
    end

    // Read byte for this channel, built from pre-edge state so a same-edge
    // write is not visible in the returned data.
    always_comb begin
      rb = 8'h00;
      case (off[4:2])
        3'd0: if (byte_ok) rb = get_byte(sh[0], off[1:0]);
        3'd1: if (byte_ok) rb = get_byte(sh[1], off[1:0]);
        3'd2: if (byte_ok) rb = get_byte(sh[2], off[1:0]);
        3'd3: begin
          // Byte 0 comes from the live counter (it is being snapshotted on
          // this edge); the upper bytes come from the earlier snapshot.
          if (off[1:0] == 2'd0) rb = get_byte(cnt, 2'd0);
          else if (byte_ok)     rb = get_byte(snap, off[1:0]);
        end
        3'd4: begin
          case (off[1:0])
            2'd0:    rb = {4'h0, ctrl};
            2'd1:    rb = psc;
            2'd2:    rb = fn;
            default: rb = 8'h00;
          endcase
        end
        3'd5:    if (off[1:0] == 2'd0) rb = {7'h00, pend};
        default: rb = 8'h00;
      endcase
    end

    assign rd_byte[g] = rb;

    assign period  [g*CNT_W +: CNT_W] = act[0];
    assign compare1[g*CNT_W +: CNT_W] = act[1];
    assign compare2[g*CNT_W +: CNT_W] = act[2];
    assign en[g]          = ctrl[0];
    assign upnotdown[g]   = ctrl[1];
    assign pwm_en[g]      = ctrl[2];
    assign count_reset[g] = crst;
    assign upd_pending[g] = pend;
    assign prescale [g*8 +: 8] = psc;
    assign functions[g*8 +: 8] = fn;
  end

  logic [7:0] rd_mux;

  always_comb begin
    rd_mux = 8'h00;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_ok && int'(ch_idx) == k) rd_mux = rd_byte[k];
    end
  end

  // data_read holds its value until the next sampled read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_read <= 8'h00;
    end else if (bus.read) begin
      bus.data_read <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pwm_regs_mc.sv
// tb/tb_pwm_regs_mc.sv - directed self-checking bench for pwm_regs_mc
module tb_pwm_regs_mc;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_CH*CNT_W-1:0] counter_val;
  logic [NUM_CH-1:0]       update_strobe;
  logic [NUM_CH*CNT_W-1:0] period, compare1, compare2;
  logic [NUM_CH-1:0]       en, upnotdown, pwm_en, count_reset, upd_pending;
  logic [NUM_CH*8-1:0]     prescale, functions;

  int checks   = 0;
  int failures = 0;

  pwm_regs_mc_if bus ();

  pwm_regs_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .counter_val   (counter_val),
    .update_strobe (update_strobe),
    .period        (period),
    .compare1      (compare1),
    .compare2      (compare2),
    .en            (en),
    .upnotdown     (upnotdown),
    .pwm_en        (pwm_en),
    .count_reset   (count_reset),
    .upd_pending   (upd_pending),
    .prescale      (prescale),
    .functions     (functions)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.write      = 1'b1;
    bus.addr       = a;
    bus.data_write = d;
    @(negedge clk);
    bus.write      = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    @(negedge clk);
    bus.read = 1'b1;
    bus.addr = a;
    @(negedge clk);
    bus.read = 1'b0;
  endtask

  task automatic strobe(input logic [NUM_CH-1:0] s);
    @(negedge clk);
    update_strobe = s;
    @(negedge clk);
    update_strobe = '0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.addr       = 8'h00;
    bus.data_write = 8'h00;
    counter_val    = '0;
    update_strobe  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_period",   period, 64'h0);
    check("rst_cmp",      {compare1, compare2}, 64'h0);
    check("rst_ctrl",     {en, upnotdown, pwm_en, count_reset, upd_pending}, 64'h0);
    check("rst_bytes",    {prescale, functions}, 64'h0);
    check("rst_dread",    bus.data_read, 64'h0);
    rd(8'h00);
    check("rd_ch0_p0",    bus.data_read, 64'h0);

    // Shadowed period write on ch1, loaded by strobe
    wr(8'h20, 8'h34);
    wr(8'h21, 8'h12);
    check("ch1_per_before", period[16 +: 16], 64'h0);
    check("ch1_pend_set",   upd_pending, 64'h2);
    rd(8'h21);
    check("ch1_shadow_rd",  bus.data_read, 64'h12);
    rd(8'h34);
    check("ch1_status",     bus.data_read, 64'h01);
    strobe(4'b0010);
    check("ch1_per_after",  period[16 +: 16], 64'h1234);
    check("ch1_pend_clr",   upd_pending, 64'h0);

    // Shadow bypass on ch2
    wr(8'h50, 8'h08);
    wr(8'h44, 8'hAA);
    check("ch2_cmp1_lo",    compare1[32 +: 16], 64'h00AA);
    wr(8'h45, 8'h55);
    check("ch2_cmp1",       compare1[32 +: 16], 64'h55AA);
    check("ch2_pend",       upd_pending, 64'h0);
    rd(8'h50);
    check("ch2_ctrl_rd",    bus.data_read, 64'h08);
    check("ctrl_bits",      {en, upnotdown, pwm_en}, 64'h0);

    // Coherent counter snapshot on ch0
    counter_val[15:0] = 16'hABCD;
    rd(8'h0C);
    check("cnt_b0",         bus.data_read, 64'hCD);
    counter_val[15:0] = 16'h1111;
    rd(8'h0D);
    check("cnt_b1_snap",    bus.data_read, 64'hAB);

    // Counter reset pulse on ch3
    wr(8'h73, 8'hFF);
    check("creset_on",      count_reset, 64'h8);
    @(negedge clk);
    check("creset_off",     count_reset, 64'h0);

    // Back-to-back counter reset writes extend the pulse
    @(negedge clk);
    bus.write = 1'b1; bus.addr = 8'h13; bus.data_write = 8'h00;
    @(negedge clk);
    check("creset_bb1",     count_reset, 64'h1);
    @(negedge clk);
    bus.write = 1'b0;
    check("creset_bb2",     count_reset, 64'h1);
    @(negedge clk);
    check("creset_bb_end",  count_reset, 64'h0);

    // Unmapped channel and unimplemented byte lane
    rd(8'hFF);
    check("rd_bad_ch",      bus.data_read, 64'h0);
    wr(8'h22, 8'h77);
    rd(8'h22);
    check("rd_byte2",       bus.data_read, 64'h0);
    check("byte2_no_pend",  upd_pending, 64'h0);

    // Shadow write coinciding with strobe on ch0
    @(negedge clk);
    bus.write = 1'b1; bus.addr = 8'h00; bus.data_write = 8'h77;
    update_strobe = 4'b0001;
    @(negedge clk);
    bus.write = 1'b0; update_strobe = '0;
    check("coinc_per",      period[15:0], 64'h0077);
    check("coinc_pend",     upd_pending, 64'h0);

    // Simultaneous read and write returns the pre-write value
    wr(8'h11, 8'h05);
    @(negedge clk);
    bus.read = 1'b1; bus.write = 1'b1; bus.addr = 8'h11; bus.data_write = 8'h09;
    @(negedge clk);
    bus.read = 1'b0; bus.write = 1'b0;
    check("rw_old_data",    bus.data_read, 64'h05);
    check("rw_new_psc",     prescale[7:0], 64'h09);

    // Asynchronous reset mid-pulse with an update pending
    wr(8'h20, 8'h99);
    wr(8'h73, 8'h01);
    check("pre_rst_pulse",  {count_reset, upd_pending}, 64'h82);
    #1 rst_n = 1'b0;
    #1;
    check("arst_pulse",     {count_reset, upd_pending}, 64'h0);
    check("arst_period",    period, 64'h0);
    check("arst_ctrl",      {compare1, prescale}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    strobe(4'b0010);
    check("arst_shadow_drop", period[16 +: 16], 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
